leitor_fila: RTL and testbench

Read-side controller for the 8-entry byte queue. It watches the queue length and issues single-cycle dequeue pulses. It captures the dequeued byte after the queue's fixed multi-cycle dequeue latency and presents it downstream on a valid/ready handshake. It spaces requests so that no dequeue is issued before the queue has returned to idle and its reported length has updated.

---
 rtl/leitor_fila.sv | 141 ++++++++++++++
 tb/tb_leitor_fila.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/leitor_fila.sv
// leitor_fila: read-side controller for the 8-entry byte queue.
// Issues single-cycle dequeue pulses while the queue reports data, captures
// the byte after the queue's fixed dequeue latency and offers it downstream
// on a valid/ready handshake. Consecutive requests are spaced by MIN_GAP
// cycles so the queue is idle and its lagging length report is current.
//
// Optional build macro LEITOR_CHECK_EN adds a sticky err output that flags
// a length report which failed to drop by one after a dequeue.
module leitor_fila #(
  parameter int DEQ_LAT = 2,
  parameter int MIN_GAP = 5
) (
  input  logic       clk_10KHz,
  input  logic       reset,
  input  logic [7:0] fila_data_in,
  input  logic [7:0] fila_len_in,
  output logic       fila_dequeue_out,
  input  logic       drain_en,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] rd_count,
`ifdef LEITOR_CHECK_EN
  output logic       busy,
  output logic       err
`else
  output logic       busy
`endif
);

  localparam int LAT_W = (DEQ_LAT > 1) ? $clog2(DEQ_LAT) : 1;
  localparam int GAP_W = $clog2(MIN_GAP + 1);

  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(DEQ_LAT - 1);
  localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);
  localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(MIN_GAP);
  localparam logic [GAP_W-1:0] GAP_REQ  = GAP_W'(MIN_GAP - 1);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t           state;
  logic [LAT_W-1:0] lat_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             req_ok;

`ifdef LEITOR_CHECK_EN
  logic [7:0]       len_snap;
  logic [7:0]       len_expect;
  logic             len_bad;
`endif

  // Request qualification. The gap counter holds the cycles elapsed since
  // the last request cycle, so a request decided now lands one cycle later;
  // testing against MIN_GAP-1 puts request-to-request spacing at MIN_GAP.
  always_comb begin
    req_ok = drain_en && (fila_len_in != 8'd0) && !out_valid &&
             (gap_cnt >= GAP_REQ);
  end

`ifdef LEITOR_CHECK_EN
  // Length after a dequeue should be one below the snapshot; growth from
  // concurrent enqueues is tolerated unless it exactly cancels the dequeue.
  always_comb begin
    len_expect = len_snap - 8'd1;
    len_bad    = (fila_len_in < len_expect) || (fila_len_in == len_snap);
  end
`endif

  // Read sequencer: request, wait out the dequeue latency, hold the byte
  // until downstream takes it. All outputs are registered here.
  always_ff @(posedge clk_10KHz or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      fila_dequeue_out <= 1'b0;
      out_data         <= 8'd0;
      out_valid        <= 1'b0;
      rd_count         <= 8'd0;
      busy             <= 1'b0;
      lat_cnt          <= '0;
      gap_cnt          <= GAP_MAX;
`ifdef LEITOR_CHECK_EN
      len_snap         <= 8'd0;
      err              <= 1'b0;
`endif
    end else begin
      fila_dequeue_out <= 1'b0;

      if (gap_cnt < GAP_MAX)
        gap_cnt <= gap_cnt + GAP_ONE;

`ifdef LEITOR_CHECK_EN
      // The counter is about to reach MIN_GAP: the length report now
      // reflects the last dequeue.
      if (gap_cnt == GAP_REQ && len_bad)
        err <= 1'b1;
`endif

      case (state)
        IDLE: begin
          if (req_ok) begin
            state            <= REQ;
            fila_dequeue_out <= 1'b1;
            busy             <= 1'b1;
            gap_cnt          <= '0;
          end
        end
        REQ: begin
          state   <= WAIT;
          lat_cnt <= '0;
`ifdef LEITOR_CHECK_EN
          len_snap <= fila_len_in;
`endif
        end
        WAIT: begin
          if (lat_cnt == LAT_LAST) begin
            out_data  <= fila_data_in;
            out_valid <= 1'b1;
            state     <= HOLD;
          end else begin
            lat_cnt <= lat_cnt + LAT_ONE;
          end
        end
        HOLD: begin
          // Returning to IDLE first keeps a request out of the consume cycle.
          if (out_ready) begin
            out_valid <= 1'b0;
            rd_count  <= rd_count + 8'd1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_leitor_fila.sv
// Testbench for leitor_fila: a behavioural queue drives the DUT, and a
// scoreboard of enqueued bytes plus request-timing rules checks the reads.
`timescale 1ns/1ps
module tb_leitor_fila;
  localparam int DEQ_LAT = 2;
  localparam int MIN_GAP = 5;

  logic       clk_10KHz = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] fila_data_in = 8'd0;
  logic [7:0] fila_len_in = 8'd0;
  logic       fila_dequeue_out;
  logic       drain_en = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] rd_count;
  logic       busy;
`ifdef LEITOR_CHECK_EN
  logic       err;
`endif

  always #5 clk_10KHz = ~clk_10KHz;

  leitor_fila #(.DEQ_LAT(DEQ_LAT), .MIN_GAP(MIN_GAP)) dut (
    .clk_10KHz       (clk_10KHz),
    .reset           (reset),
    .fila_data_in    (fila_data_in),
    .fila_len_in     (fila_len_in),
    .fila_dequeue_out(fila_dequeue_out),
    .drain_en        (drain_en),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .rd_count        (rd_count),
`ifdef LEITOR_CHECK_EN
    .busy            (busy),
    .err             (err)
`else
    .busy            (busy)
`endif
  );

  // Queue model and scoreboard state
  logic [7:0] q[$];
  logic [7:0] exp_q[$];
  int         pulses[$];
  int         cyc = 0;
  int         last_pulse = -100;
  int         dcnt = 0;
  int         last_size = 0;
  logic [7:0] pend = 8'd0;
  logic [7:0] rd_exp = 8'd0;
  bit         no_dec = 1'b0;
  int         errors = 0;
  int         checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    q.push_back(b);
    exp_q.push_back(b);
  endtask

  task automatic model_clear();
    q.delete();
    exp_q.delete();
    dcnt = 0;
    last_pulse = -100;
    rd_exp = 8'd0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_deq"},   32'(fila_dequeue_out), 32'd0);
    chk({tag, "_valid"}, 32'(out_valid),        32'd0);
    chk({tag, "_data"},  32'(out_data),         32'd0);
    chk({tag, "_rd"},    32'(rd_count),         32'd0);
    chk({tag, "_busy"},  32'(busy),             32'd0);
  endtask

  // One clock cycle: sample the DUT mid-cycle, then advance the queue model.
  task automatic tick();
    logic deq_s, hs;
    logic [7:0] d_s;
    logic [31:0] want;
    @(negedge clk_10KHz);
    deq_s = fila_dequeue_out;
    hs    = out_valid && out_ready;
    d_s   = out_data;
    if (deq_s === 1'b1) begin
      pulses.push_back(cyc);
      chk("pulse_gap", 32'((cyc - last_pulse) >= MIN_GAP), 32'd1);
      chk("busy_in_req", 32'(busy), 32'd1);
      last_pulse = cyc;
    end
    if (last_pulse >= 0 && cyc == last_pulse + DEQ_LAT)
      chk("valid_before_capture", 32'(out_valid), 32'd0);
    if (last_pulse >= 0 && cyc == last_pulse + DEQ_LAT + 1)
      chk("valid_after_capture", 32'(out_valid), 32'd1);
    if (hs) begin
      want = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'hxxxx_xxxx;
      chk("out_data", 32'(d_s), want);
      rd_exp = rd_exp + 8'd1;
    end
    @(posedge clk_10KHz);
    #1;
    cyc++;
    if (!no_dec) fila_len_in = 8'(last_size);
    if (deq_s === 1'b1) begin
      pend = (q.size() > 0) ? q.pop_front() : 8'hEE;
      dcnt = DEQ_LAT - 1;
      fila_data_in = (dcnt == 0) ? pend : ~pend;
    end else if (dcnt > 0) begin
      dcnt--;
      if (dcnt == 0) fila_data_in = pend;
    end
    last_size = q.size();
  endtask

  initial begin
    int m;
    int left;

    // Reset state
    #2 reset = 1'b1;
    repeat (2) @(posedge clk_10KHz);
    #1;
    check_zero("rst");
`ifdef LEITOR_CHECK_EN
    chk("rst_err", 32'(err), 32'd0);
`endif
    reset = 1'b0;

    // Three bytes drained back to back
    push(8'h11); push(8'h22); push(8'h33);
    repeat (3) tick();
    pulses.delete();
    out_ready = 1'b1;
    drain_en  = 1'b1;
    repeat (30) tick();
    chk("t1_pulses", 32'(pulses.size()), 32'd3);
    if (pulses.size() >= 3) begin
      chk("t1_gap01", 32'(pulses[1] - pulses[0]), 32'(MIN_GAP));
      chk("t1_gap12", 32'(pulses[2] - pulses[1]), 32'(MIN_GAP));
    end
    chk("t1_rd", 32'(rd_count), 32'd3);
    chk("t1_drained", 32'(exp_q.size()), 32'd0);

    // Byte held while downstream stalls
    pulses.delete();
    out_ready = 1'b0;
    push(8'hA5);
    repeat (20) tick();
    chk("t2_pulses", 32'(pulses.size()), 32'd1);
    chk("t2_valid", 32'(out_valid), 32'd1);
    chk("t2_data", 32'(out_data), 32'hA5);
    chk("t2_busy", 32'(busy), 32'd1);
    out_ready = 1'b1;
    repeat (3) tick();
    chk("t2_rd", 32'(rd_count), 32'd4);
    chk("t2_valid_off", 32'(out_valid), 32'd0);
    chk("t2_idle", 32'(busy), 32'd0);

    // drain_en dropped in the cycle after a request
    pulses.delete();
    push(8'h5A); push(8'h6B);
    for (int i = 0; i < 20 && pulses.size() == 0; i++) tick();
    drain_en = 1'b0;
    chk("t3_pulse_seen", 32'(pulses.size()), 32'd1);
    repeat (20) tick();
    chk("t3_pulses", 32'(pulses.size()), 32'd1);
    chk("t3_rd", 32'(rd_count), 32'd5);
    chk("t3_left", 32'(q.size()), 32'd1);
    chk("t3_valid", 32'(out_valid), 32'd0);
    drain_en = 1'b1;
    repeat (10) tick();
    chk("t3_rd_flush", 32'(rd_count), 32'd6);

    // Reset asserted while waiting on the queue
    pulses.delete();
    push(8'h77);
    for (int i = 0; i < 20 && pulses.size() == 0; i++) tick();
    chk("t4_pulse_seen", 32'(pulses.size()), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_zero("t4");
    model_clear();
    drain_en = 1'b0;
    push(8'h81); push(8'h82);
    repeat (3) tick();
    reset = 1'b0;
    repeat (2) tick();
    pulses.delete();
    m = cyc;
    drain_en = 1'b1;
    tick();
    tick();
    chk("t4_first_pulse", 32'((pulses.size() > 0) ? pulses[0] : -1), 32'(m + 1));
    repeat (15) tick();
    chk("t4_rd", 32'(rd_count), 32'd2);

    // Randomised traffic up to 256 deliveries: counter wraps
    left = 254;
    for (int i = 0; i < 20000 && (left > 0 || exp_q.size() > 0); i++) begin
      if (left > 0 && q.size() < 8 && $urandom_range(0, 1) == 1) begin
        push(8'($urandom));
        left--;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      drain_en  = ($urandom_range(0, 7) != 0);
      tick();
    end
    chk("t5_all_delivered", 32'(exp_q.size() + left), 32'd0);
    out_ready = 1'b1;
    drain_en  = 1'b1;
    repeat (6) tick();
    chk("t5_wrap", 32'(rd_count), 32'd0);
    chk("t5_rd_model", 32'(rd_count), 32'(rd_exp));
    chk("t5_idle", 32'(busy), 32'd0);

`ifdef LEITOR_CHECK_EN
    // Length report stuck after a dequeue
    reset = 1'b1;
    #1;
    model_clear();
    drain_en  = 1'b0;
    out_ready = 1'b0;
    tick();
    reset = 1'b0;
    chk("t6_err_after_reset", 32'(err), 32'd0);
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    repeat (3) tick();
    no_dec   = 1'b1;
    drain_en = 1'b1;
    repeat (12) tick();
    chk("t6_err_set", 32'(err), 32'd1);
    repeat (10) tick();
    chk("t6_err_sticky", 32'(err), 32'd1);

    // Correct length behaviour leaves err clear
    reset = 1'b1;
    #1;
    model_clear();
    no_dec   = 1'b0;
    drain_en = 1'b0;
    tick();
    reset = 1'b0;
    chk("t6_err_cleared", 32'(err), 32'd0);
    push(8'h10); push(8'h20); push(8'h30); push(8'h40);
    repeat (3) tick();
    out_ready = 1'b1;
    drain_en  = 1'b1;
    repeat (40) tick();
    chk("t6_err_clean", 32'(err), 32'd0);
    chk("t6_rd", 32'(rd_count), 32'd4);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
